// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM encoding and requester IDs.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;
  localparam int   LAT_W  = 4;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way request picker: load/store first unless it won last time and fetch waits.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic if_req_i,
  input  logic ls_req_i,
  input  logic last_ls_i,
  output logic win_valid_o,
  output logic win_id_o
);
  assign win_valid_o = if_req_i | ls_req_i;
  assign win_id_o    = (ls_req_i && !(if_req_i && last_ls_i)) ? REQ_LS : REQ_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store, fixed MEM_LAT access.
// Optional perf counters (if_cnt, ls_cnt, conflict_cnt) when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       if_cnt,
  output logic [31:0]       ls_cnt,
  output logic [31:0]       conflict_cnt,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               last_ls_q, last_ls_d;
  logic               owner_q, owner_d;
  logic               if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic               if_valid_q, if_valid_d, ls_valid_q, ls_valid_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               win_valid, win_id;

  arb_pick u_pick (
    .if_req_i    (if_req),
    .ls_req_i    (ls_req),
    .last_ls_i   (last_ls_q),
    .win_valid_o (win_valid),
    .win_id_o    (win_id)
  );

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    last_ls_d   = last_ls_q;
    owner_d     = owner_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: if (win_valid) begin
        owner_d     = win_id;
        last_ls_d   = win_id;
        if_gnt_d    = (win_id == REQ_IF);
        ls_gnt_d    = (win_id == REQ_LS);
        mem_en_d    = 1'b1;
        mem_we_d    = (win_id == REQ_LS) && ls_we;
        mem_addr_d  = (win_id == REQ_LS) ? ls_addr : if_addr;
        mem_wdata_d = (win_id == REQ_LS) ? ls_wdata : '0;
        lat_cnt_d   = LAT_W'(MEM_LAT - 1);
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == REQ_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            ls_valid_d = 1'b1;
            // stores leave the last load data visible
            if (!mem_we_q) ls_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      last_ls_q   <= 1'b0;
      owner_q     <= REQ_IF;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      last_ls_q   <= last_ls_d;
      owner_q     <= owner_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_valid_q  <= if_valid_d;
      ls_valid_q  <= ls_valid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_valid  = if_valid_q;
  assign ls_valid  = ls_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_cnt_q, ls_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_cnt_q       <= '0;
      ls_cnt_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (if_gnt_d) if_cnt_q <= if_cnt_q + 32'd1;
      if (ls_gnt_d) ls_cnt_q <= ls_cnt_q + 32'd1;
      if (state_q == IDLE && if_req && ls_req) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign if_cnt       = if_cnt_q;
  assign ls_cnt       = ls_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus arbitration/reset sequences.
module tb_mem_port_arbiter;
  localparam logic [31:0] K   = 32'h5A5A_0000;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;
  localparam int NROW = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic        if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        model_en = 1'b0;
  logic [31:0] tbl_rdata = BAD;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_cnt, ls_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  assign mem_rdata = model_en ? (mem_addr ^ K) : tbl_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
`ifdef MEM_ARB_PERF_EN
    .if_cnt(if_cnt), .ls_cnt(ls_cnt), .conflict_cnt(conflict_cnt),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata, rdata;
    logic        e_if_gnt, e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_ls_gnt, e_ls_valid;
    logic [31:0] e_ls_rdata;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t tbl [NROW];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr, lw,
                              input logic [31:0] la, lwd, rd,
                              input logic eig, eiv, input logic [31:0] eir,
                              input logic elg, elv, input logic [31:0] elr,
                              input logic een, ewe, input logic [31:0] ea, ewd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
    v.ls_addr = la; v.ls_wdata = lwd; v.rdata = rd;
    v.e_if_gnt = eig; v.e_if_valid = eiv; v.e_if_rdata = eir;
    v.e_ls_gnt = elg; v.e_ls_valid = elv; v.e_ls_rdata = elr;
    v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  function automatic logic [159:0] snap();
    return {26'b0, if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
            mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 0; ls_req = 0; ls_we = 0;
    @(posedge clk); #2;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    logic [159:0] exp, got;
    int gid [4];
    int gcyc [4];
    int ng, c, vcyc;
    bit seen;

    // single fetch, store, load, store-after-load
    tbl[0]  = mk(1,32'h10,0,0,0,0,BAD,           0,0,0,    0,0,0,          0,0,0,0);
    tbl[1]  = mk(1,32'h10,0,0,0,0,BAD,           1,0,0,    0,0,0,          1,0,32'h10,0);
    tbl[2]  = mk(1,32'h10,0,0,0,0,32'h13,        0,0,0,    0,0,0,          1,0,32'h10,0);
    tbl[3]  = mk(0,0,0,0,0,0,BAD,                0,1,32'h13,0,0,0,         0,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,0,0,         0,0,0,0);
    tbl[5]  = mk(0,0,1,1,32'h100,32'hDEADBEEF,BAD,0,0,32'h13,0,0,0,        0,0,0,0);
    tbl[6]  = mk(0,0,1,1,32'h100,32'hDEADBEEF,BAD,0,0,32'h13,1,0,0,        1,1,32'h100,32'hDEADBEEF);
    tbl[7]  = mk(0,0,1,1,32'h100,32'hDEADBEEF,BAD,0,0,32'h13,0,0,0,        1,1,32'h100,32'hDEADBEEF);
    tbl[8]  = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,1,0,         0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,0,0,         0,0,0,0);
    tbl[10] = mk(0,0,1,0,32'h200,0,BAD,          0,0,32'h13,0,0,0,         0,0,0,0);
    tbl[11] = mk(0,0,1,0,32'h200,0,BAD,          0,0,32'h13,1,0,0,         1,0,32'h200,0);
    tbl[12] = mk(0,0,1,0,32'h200,0,32'h55AA1234, 0,0,32'h13,0,0,0,         1,0,32'h200,0);
    tbl[13] = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,1,32'h55AA1234,0,0,0,0);
    tbl[14] = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,0,32'h55AA1234,0,0,0,0);
    tbl[15] = mk(0,0,1,1,32'h104,32'h0BADF00D,BAD,0,0,32'h13,0,0,32'h55AA1234,0,0,0,0);
    tbl[16] = mk(0,0,1,1,32'h104,32'h0BADF00D,BAD,0,0,32'h13,1,0,32'h55AA1234,1,1,32'h104,32'h0BADF00D);
    tbl[17] = mk(0,0,1,1,32'h104,32'h0BADF00D,BAD,0,0,32'h13,0,0,32'h55AA1234,1,1,32'h104,32'h0BADF00D);
    tbl[18] = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,1,32'h55AA1234,0,0,0,0);
    tbl[19] = mk(0,0,0,0,0,0,BAD,                0,0,32'h13,0,0,32'h55AA1234,0,0,0,0);

    do_reset();
    for (int i = 0; i < NROW; i++) begin
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      ls_req = tbl[i].ls_req; ls_we = tbl[i].ls_we;
      ls_addr = tbl[i].ls_addr; ls_wdata = tbl[i].ls_wdata; tbl_rdata = tbl[i].rdata;
      @(negedge clk);
      got = snap();
      exp = {26'b0, tbl[i].e_if_gnt, tbl[i].e_if_valid, tbl[i].e_if_rdata,
             tbl[i].e_ls_gnt, tbl[i].e_ls_valid, tbl[i].e_ls_rdata,
             tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata};
      // address/data bus content is don't-care while mem_en is low
      if (!tbl[i].e_en) got[63:0] = exp[63:0];
      check($sformatf("row%0d", i), got, exp);
      next_cycle();
    end
    if_req = 0; ls_req = 0;

    // both requesting from reset: LS, IF, LS, IF every MEM_LAT+2 cycles
    model_en = 1;
    do_reset();
    if_req = 1; if_addr = 32'h40; ls_req = 1; ls_we = 0; ls_addr = 32'h80; ls_wdata = 0;
    ng = 0;
    for (c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (if_valid) check("alt_if_rdata", {128'b0, if_rdata}, {128'b0, 32'h40 ^ K});
      if (ls_valid) check("alt_ls_rdata", {128'b0, ls_rdata}, {128'b0, 32'h80 ^ K});
      if (if_gnt || ls_gnt) begin
        gid[ng] = ls_gnt ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
      if (ng < 4) next_cycle();
    end
    check("alt_grant_count", 160'(ng), 160'(4));
`ifdef MEM_ARB_PERF_EN
    check("perf_conflict", {128'b0, conflict_cnt}, 160'(4));
    check("perf_grants", {128'b0, if_cnt + ls_cnt}, 160'(4));
`endif
    if (ng == 4) begin
      check("alt_first_gnt_cycle", 160'(gcyc[0]), 160'(1));
      check("alt_order", {156'b0, gid[0][0], gid[1][0], gid[2][0], gid[3][0]}, {156'b0, 4'b1010});
      for (int i = 1; i < 4; i++)
        check($sformatf("alt_period%0d", i), 160'(gcyc[i] - gcyc[i-1]), 160'(4));
    end
    next_cycle();
    if_req = 0; ls_req = 0;

    // three LS-only grants, then fetch joins and must win
    do_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h80;
    ng = 0; seen = 0;
    for (c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (ng == 3 && (if_gnt || ls_gnt)) begin
        check("fair_if_wins", {158'b0, if_gnt, ls_gnt}, {158'b0, 2'b10});
        seen = 1;
      end else if (ls_gnt) ng++;
      next_cycle();
      if (ng == 3) if_req = 1;
    end
    if (!seen) check("fair_timeout", 160'(0), 160'(1));
    if_req = 0; ls_req = 0;
    repeat (6) next_cycle();

    // reset during ACCESS drops the fetch; reissue completes
    do_reset();
    if_req = 1; if_addr = 32'h44;
    next_cycle();
    next_cycle();
    #1 rst_n = 0;
    #1 check("rst_mid_outputs", snap(), 160'b0);
    if_req = 0;
    @(posedge clk); #1 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_valid || ls_valid) seen = 1;
      next_cycle();
    end
    check("rst_no_valid", 160'(seen), 160'(0));
    if_req = 1;
    vcyc = -1;
    for (c = 0; c < 20 && vcyc < 0; c++) begin
      @(negedge clk);
      if (if_valid) begin
        vcyc = c;
        check("reissue_rdata", {128'b0, if_rdata}, {128'b0, 32'h44 ^ K});
      end
      next_cycle();
    end
    check("reissue_latency", 160'(vcyc), 160'(3));
    if_req = 0;
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
